// File: rtl/dp_ram_arb_pkg.sv
// Shared widths and RAM command type for the dual-port RAM arbiter.
// The optional address-collision hold-off is selected by DP_RAM_ARB_COLLISION_EN.
package dp_ram_arb_pkg;

    localparam int ADDR_W   = 3;
    localparam int WDATA_W  = 2;
    localparam int RDATA_W  = 4;
    localparam int MAX_NREQ = 8;

    typedef struct packed {
        logic               en;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] data;
    } ram_cmd_t;

    localparam ram_cmd_t RAM_CMD_IDLE = '0;

    // Two commands touching one word where at least one writes.
    function automatic logic addr_conflict(input ram_cmd_t a, input ram_cmd_t b);
        return a.en && b.en && (a.addr == b.addr) && (a.we || b.we);
    endfunction

endpackage

// File: rtl/dp_ram_arbiter_rr_pick.sv
// Cyclic first-set finder: returns the first set bit of i_vec at or after
// i_start, wrapping around, plus a flag telling whether any bit was set.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_vec,
    input  logic [IW-1:0] i_start,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Walk the vector from i_start in cyclic order and latch the first hit.
    always_comb begin
        int   pos;
        logic hit;
        pos     = 0;
        hit     = 1'b0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos     = (int'(i_start) + k) % N;
            hit     = !o_found && i_vec[pos];
            o_idx   = hit ? IW'(pos) : o_idx;
            o_found = o_found | hit;
        end
    end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a dual-port RAM.
// Define DP_RAM_ARB_COLLISION_EN to hold back port B on a same-address write hazard.
module dp_ram_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [NREQ*WDATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [NREQ*RDATA_W-1:0] rdata,
    output logic                    ram_ena,
    output logic                    ram_wea,
    output logic                    ram_enb,
    output logic                    ram_web,
    output logic [ADDR_W-1:0]       ram_ada,
    output logic [ADDR_W-1:0]       ram_adb,
    output logic [WDATA_W-1:0]      ram_ina,
    output logic [WDATA_W-1:0]      ram_inb,
    input  logic [RDATA_W-1:0]      ram_outa,
    input  logic [RDATA_W-1:0]      ram_outb
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NREQ - 1)) begin
            f_next = '0;
        end else begin
            f_next = idx + IDX_W'(1);
        end
    endfunction

    logic [NREQ-1:0]         w_elig;
    logic [NREQ-1:0]         w_mask_b;
    logic [NREQ-1:0]         w_gnt_nxt;
    logic [IDX_W-1:0]        w_a_idx;
    logic [IDX_W-1:0]        w_b_idx;
    logic [IDX_W-1:0]        w_b_start;
    logic [IDX_W-1:0]        w_ptr_nxt;
    logic                    w_a_found;
    logic                    w_b_found;
    logic                    w_b_go;
    logic                    w_collide;
    ram_cmd_t                w_cmd_a;
    ram_cmd_t                w_cmd_b_raw;
    ram_cmd_t                w_cmd_b;

    logic [NREQ-1:0]         r_gnt;
    logic [IDX_W-1:0]        r_ptr;
    ram_cmd_t                r_cmd_a;
    ram_cmd_t                r_cmd_b;
    logic [IDX_W-1:0]        r_id_a;
    logic [IDX_W-1:0]        r_id_b;
    logic                    r_rd_a_v;
    logic                    r_rd_b_v;
    logic [IDX_W-1:0]        r_rd_a_id;
    logic [IDX_W-1:0]        r_rd_b_id;
    logic [NREQ-1:0]         r_rvalid;
    logic [NREQ*RDATA_W-1:0] r_rdata;

    // A requester whose grant is pulsing this cycle is still holding req; skip it.
    assign w_elig    = req & ~r_gnt;
    assign w_b_start = f_next(w_a_idx);
    assign w_mask_b  = w_elig & ~(NREQ'(1'b1) << w_a_idx);

    rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick_a (
        .i_vec   (w_elig),
        .i_start (r_ptr),
        .o_idx   (w_a_idx),
        .o_found (w_a_found)
    );

    rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick_b (
        .i_vec   (w_mask_b),
        .i_start (w_b_start),
        .o_idx   (w_b_idx),
        .o_found (w_b_found)
    );

    // Assemble candidate commands for both winners from their request slices.
    always_comb begin
        w_cmd_a     = RAM_CMD_IDLE;
        w_cmd_b_raw = RAM_CMD_IDLE;
        if (w_a_found) begin
            w_cmd_a.en   = 1'b1;
            w_cmd_a.we   = req_we[w_a_idx];
            w_cmd_a.addr = req_addr[int'(w_a_idx)*ADDR_W +: ADDR_W];
            w_cmd_a.data = req_wdata[int'(w_a_idx)*WDATA_W +: WDATA_W];
        end else begin
            w_cmd_a = RAM_CMD_IDLE;
        end
        if (w_b_found) begin
            w_cmd_b_raw.en   = 1'b1;
            w_cmd_b_raw.we   = req_we[w_b_idx];
            w_cmd_b_raw.addr = req_addr[int'(w_b_idx)*ADDR_W +: ADDR_W];
            w_cmd_b_raw.data = req_wdata[int'(w_b_idx)*WDATA_W +: WDATA_W];
        end else begin
            w_cmd_b_raw = RAM_CMD_IDLE;
        end
    end

`ifdef DP_RAM_ARB_COLLISION_EN
    assign w_collide = addr_conflict(w_cmd_a, w_cmd_b_raw);
`else
    assign w_collide = 1'b0;
`endif

    // Final B decision, grant vector and pointer advance past the last winner.
    always_comb begin
        w_b_go    = w_b_found & ~w_collide;
        w_cmd_b   = w_b_go ? w_cmd_b_raw : RAM_CMD_IDLE;
        w_gnt_nxt = ({NREQ{w_a_found}} & (NREQ'(1'b1) << w_a_idx))
                  | ({NREQ{w_b_go}}    & (NREQ'(1'b1) << w_b_idx));
        if (w_b_go) begin
            w_ptr_nxt = f_next(w_b_idx);
        end else if (w_a_found) begin
            w_ptr_nxt = f_next(w_a_idx);
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    // Arbitration result register: grants, RAM commands and owner of each port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cmd_a <= RAM_CMD_IDLE;
            r_cmd_b <= RAM_CMD_IDLE;
            r_id_a  <= '0;
            r_id_b  <= '0;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cmd_a <= w_cmd_a;
            r_cmd_b <= w_cmd_b;
            r_id_a  <= w_a_idx;
            r_id_b  <= w_b_idx;
        end
    end

    // Track reads while the RAM produces its registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_a_v  <= 1'b0;
            r_rd_b_v  <= 1'b0;
            r_rd_a_id <= '0;
            r_rd_b_id <= '0;
        end else begin
            r_rd_a_v  <= r_cmd_a.en & ~r_cmd_a.we;
            r_rd_b_v  <= r_cmd_b.en & ~r_cmd_b.we;
            r_rd_a_id <= r_id_a;
            r_rd_b_id <= r_id_b;
        end
    end

    // Capture RAM output into the owner's rdata slice and pulse its rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= ({NREQ{r_rd_a_v}} & (NREQ'(1'b1) << r_rd_a_id))
                      | ({NREQ{r_rd_b_v}} & (NREQ'(1'b1) << r_rd_b_id));
            for (int i = 0; i < NREQ; i++) begin
                if (r_rd_a_v && (r_rd_a_id == IDX_W'(i))) begin
                    r_rdata[i*RDATA_W +: RDATA_W] <= ram_outa;
                end else if (r_rd_b_v && (r_rd_b_id == IDX_W'(i))) begin
                    r_rdata[i*RDATA_W +: RDATA_W] <= ram_outb;
                end
            end
        end
    end

    assign gnt     = r_gnt;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign ram_ena = r_cmd_a.en;
    assign ram_wea = r_cmd_a.we;
    assign ram_ada = r_cmd_a.addr;
    assign ram_ina = r_cmd_a.data;
    assign ram_enb = r_cmd_b.en;
    assign ram_web = r_cmd_b.we;
    assign ram_adb = r_cmd_b.addr;
    assign ram_inb = r_cmd_b.data;

endmodule
